// File: rtl/switch_input_debouncer.sv
// Synchronises and debounces raw switch pins, emits per-bit edge pulses and
// offers each debounced change to a downstream consumer as a valid/ready event.
module switch_input_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             SYSTEMCLOCK,
    input  logic             FPGA_RESET,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_stable,
    output logic [WIDTH-1:0] switch_rise,
    output logic [WIDTH-1:0] switch_fall,
    output logic             change_valid,
    output logic [WIDTH-1:0] change_data,
    input  logic             change_ready,
    output logic             change_overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1_p0;
    logic [WIDTH-1:0] sync2_p1;
    logic [WIDTH-1:0] stable_p2;
    logic [WIDTH-1:0] stable_nxt;
    logic [CNT_W-1:0] cnt_p2  [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic             chg;

    logic [WIDTH-1:0] rise_p3;
    logic [WIDTH-1:0] fall_p3;
    logic             valid_p3;
    logic [WIDTH-1:0] data_p3;
    logic             overrun_p3;

    // Stage p0/p1: two-flop synchroniser per bit
    always_ff @(posedge SYSTEMCLOCK) begin
        if (FPGA_RESET) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
        end else begin
            sync1_p0 <= switch_raw;
            sync2_p1 <= sync1_p0;
        end
    end

    // Stage p2: a bit flips only after sync2 disagrees for DEBOUNCE_CYCLES edges in a row
    always_comb begin
        stable_nxt = stable_p2;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync2_p1[i] != stable_p2[i]) begin
                if (cnt_p2[i] == CNT_LAST) begin
                    stable_nxt[i] = sync2_p1[i];
                end else begin
                    cnt_nxt[i] = cnt_p2[i] + CNT_ONE;
                end
            end
        end
    end

    assign chg = |(stable_nxt ^ stable_p2);

    always_ff @(posedge SYSTEMCLOCK) begin
        if (FPGA_RESET) begin
            stable_p2 <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_p2[i] <= '0;
            end
        end else begin
            stable_p2 <= stable_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_p2[i] <= cnt_nxt[i];
            end
        end
    end

    // Stage p3: edge pulses and the change event, all aligned with the stable update
    always_ff @(posedge SYSTEMCLOCK) begin
        if (FPGA_RESET) begin
            rise_p3    <= '0;
            fall_p3    <= '0;
            valid_p3   <= 1'b0;
            data_p3    <= '0;
            overrun_p3 <= 1'b0;
        end else begin
            rise_p3    <= stable_nxt & ~stable_p2;
            fall_p3    <= ~stable_nxt & stable_p2;
            overrun_p3 <= 1'b0;
            if (chg) begin
                // A newer snapshot replaces a pending one; only a refused event counts as lost
                valid_p3   <= 1'b1;
                data_p3    <= stable_nxt;
                overrun_p3 <= valid_p3 & ~change_ready;
            end else if (valid_p3 && change_ready) begin
                valid_p3 <= 1'b0;
            end
        end
    end

    assign switch_stable  = stable_p2;
    assign switch_rise    = rise_p3;
    assign switch_fall    = fall_p3;
    assign change_valid   = valid_p3;
    assign change_data    = data_p3;
    assign change_overrun = overrun_p3;

endmodule

// File: tb/tb_switch_input_debouncer.sv
// Directed bench for switch_input_debouncer with WIDTH=4, DEBOUNCE_CYCLES=8.
module tb_switch_input_debouncer;

    logic       clk;
    logic       rst;
    logic [3:0] raw;
    logic [3:0] stable;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       valid;
    logic [3:0] data;
    logic       ready;
    logic       overrun;

    int n_checks = 0;
    int n_fails  = 0;

    switch_input_debouncer #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .SYSTEMCLOCK   (clk),
        .FPGA_RESET    (rst),
        .switch_raw    (raw),
        .switch_stable (stable),
        .switch_rise   (rise),
        .switch_fall   (fall),
        .change_valid  (valid),
        .change_data   (data),
        .change_ready  (ready),
        .change_overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        raw   = 4'hF;
        ready = 1'b0;

        // 1: reset with all raw bits high, then release
        step(3);
        chk("rst_outputs", {stable, rise, fall, valid, data, overrun}, 32'h0);
        rst = 1'b0;
        step(9);
        chk("t1_stable_e9", stable, 4'h0);
        step(1);
        chk("t1_stable_e10", stable, 4'hF);
        chk("t1_rise_e10", rise, 4'hF);
        chk("t1_valid_e10", valid, 1'b1);
        chk("t1_data_e10", data, 4'hF);
        step(1);
        chk("t1_rise_e11", rise, 4'h0);
        chk("t1_valid_held", valid, 1'b1);
        ready = 1'b1;
        step(1);
        chk("t1_valid_accept", valid, 1'b0);
        chk("t1_data_holds", data, 4'hF);
        raw = 4'h0;
        step(10);
        chk("t1_stable_fall", stable, 4'h0);
        chk("t1_fall_pulse", fall, 4'hF);
        chk("t1_fall_data", data, 4'h0);
        step(1);
        chk("t1_fall_valid_clr", {fall, valid}, 5'h0);

        // 2: single bit rises, consumer ready
        raw = 4'h1;
        step(9);
        chk("t2_stable_e9", stable, 4'h0);
        step(1);
        chk("t2_stable_e10", stable, 4'h1);
        chk("t2_rise", rise, 4'h1);
        chk("t2_fall", fall, 4'h0);
        chk("t2_valid", valid, 1'b1);
        chk("t2_data", data, 4'h1);
        step(1);
        chk("t2_rise_clr", rise, 4'h0);
        chk("t2_valid_clr", valid, 1'b0);

        // 3: bouncing bit 1, five cycles per level, never accepted
        for (int k = 0; k < 8; k++) begin
            raw = (k % 2 == 0) ? 4'h3 : 4'h1;
            for (int c = 0; c < 5; c++) begin
                step(1);
                chk("t3_bounce", {stable, rise, fall, valid, overrun}, {4'h1, 4'h0, 4'h0, 1'b0, 1'b0});
            end
        end
        raw = 4'h3;
        step(9);
        chk("t3_stable_e9", stable, 4'h1);
        step(1);
        chk("t3_stable_e10", stable, 4'h3);
        chk("t3_rise", rise, 4'h2);
        chk("t3_valid", valid, 1'b1);
        chk("t3_data", data, 4'h3);
        step(1);
        chk("t3_valid_clr", valid, 1'b0);

        // 4: consumer stalled across two changes
        raw = 4'h0;
        step(12);
        chk("t4_settle", {stable, valid}, 5'h0);
        ready = 1'b0;
        raw   = 4'h1;
        step(10);
        chk("t4_first_evt", {valid, data, overrun}, {1'b1, 4'h1, 1'b0});
        step(3);
        chk("t4_pending", {valid, data}, {1'b1, 4'h1});
        raw = 4'h3;
        step(9);
        chk("t4_no_ovr_yet", overrun, 1'b0);
        step(1);
        chk("t4_overwrite", {valid, data, stable}, {1'b1, 4'h3, 4'h3});
        chk("t4_overrun", overrun, 1'b1);
        step(1);
        chk("t4_overrun_clr", {valid, data, overrun}, {1'b1, 4'h3, 1'b0});
        ready = 1'b1;
        step(1);
        chk("t4_accept", {valid, data}, {1'b0, 4'h3});

        // 5: accept and new change on the same edge
        ready = 1'b0;
        raw   = 4'h7;
        step(10);
        chk("t5_first_evt", {valid, data}, {1'b1, 4'h7});
        raw = 4'hF;
        step(9);
        chk("t5_pending", {valid, data}, {1'b1, 4'h7});
        ready = 1'b1;
        step(1);
        chk("t5_collide", {valid, data, overrun}, {1'b1, 4'hF, 1'b0});
        chk("t5_rise", rise, 4'h8);
        step(1);
        chk("t5_valid_clr", valid, 1'b0);

        // 6: reset in the middle of a count
        ready = 1'b0;
        raw   = 4'h0;
        step(12);
        chk("t6_pending", {stable, valid, data}, {4'h0, 1'b1, 4'h0});
        raw = 4'h4;
        step(7);
        rst = 1'b1;
        step(1);
        chk("t6_reset_out", {stable, rise, fall, valid, data, overrun}, 32'h0);
        step(1);
        rst   = 1'b0;
        ready = 1'b1;
        step(9);
        chk("t6_stable_e9", stable, 4'h0);
        step(1);
        chk("t6_stable_e10", stable, 4'h4);
        chk("t6_rise", rise, 4'h4);
        chk("t6_evt", {valid, data}, {1'b1, 4'h4});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
